// File: rtl/car_detector_if.sv
// Bundle between the loop-sensor front end and the traffic-light controller.
// master drives sensor/green/clear, slave returns the qualified request.
interface car_detector_if #(
   parameter int CNT_W = 8
);
   logic             sensor_raw;
   logic             grn;
   logic             cnt_clr;
   logic             car;
   logic             presence;
   logic [CNT_W-1:0] veh_cnt;

   modport master (
      output sensor_raw,
      output grn,
      output cnt_clr,
      input  car,
      input  presence,
      input  veh_cnt
   );

   modport slave (
      input  sensor_raw,
      input  grn,
      input  cnt_clr,
      output car,
      output presence,
      output veh_cnt
   );
endinterface

// File: rtl/car_detector.sv
// Loop-sensor qualifier feeding the traffic-light controller's car request.
// Define CAR_DET_LATCH_EN to latch the request until the controller leaves green.
module car_detector #(
   parameter int DEBOUNCE     = 4,
   parameter int MIN_PRESENCE = 8,
   parameter int CNT_W        = 8
) (
   input logic          clk,
   input logic          rst_n,
   car_detector_if.slave bus
);

   localparam int DW = $clog2(DEBOUNCE + 1);
   localparam int QW = $clog2(MIN_PRESENCE + 1);

   localparam logic [DW-1:0]    D_LAST  = DW'(DEBOUNCE - 1);
   localparam logic [QW-1:0]    Q_LOAD  = QW'(MIN_PRESENCE - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

`ifdef CAR_DET_LATCH_EN
   localparam bit LATCH = 1'b1;
`else
   localparam bit LATCH = 1'b0;
`endif

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      QUALIFY = 2'd1,
      REQUEST = 2'd2,
      SERVED  = 2'd3
   } state_t;

   logic             s1;
   logic             s2;
   logic             pres;
   logic             pres_nxt;
   logic [DW-1:0]    dcnt;
   logic [DW-1:0]    dcnt_nxt;
   logic             rise;
   logic [CNT_W-1:0] cnt;
   logic [QW-1:0]    qcnt;
   logic [QW-1:0]    qcnt_nxt;
   state_t           state;
   state_t           state_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= bus.sensor_raw;
         s2 <= s1;
      end
   end

   // presence only follows s2 after it has disagreed for DEBOUNCE edges
   always_comb begin
      pres_nxt = pres;
      dcnt_nxt = dcnt;
      if (s2 == pres) begin
         dcnt_nxt = '0;
      end else if (dcnt == D_LAST) begin
         pres_nxt = s2;
         dcnt_nxt = '0;
      end else begin
         dcnt_nxt = dcnt + 1'b1;
      end
   end

   assign rise = pres_nxt & ~pres;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pres <= 1'b0;
         dcnt <= '0;
      end else begin
         pres <= pres_nxt;
         dcnt <= dcnt_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (bus.cnt_clr) begin
         cnt <= CNT_W'(rise);
      end else if (rise && cnt != CNT_MAX) begin
         cnt <= cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         qcnt  <= '0;
      end else begin
         state <= state_nxt;
         qcnt  <= qcnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      qcnt_nxt  = qcnt;
      case (state)
         IDLE: begin
            if (pres) begin
               state_nxt = QUALIFY;
               qcnt_nxt  = Q_LOAD;
            end
         end
         QUALIFY: begin
            if (!pres) begin
               state_nxt = IDLE;
            end else if (qcnt == '0) begin
               state_nxt = REQUEST;
            end else begin
               qcnt_nxt = qcnt - 1'b1;
            end
         end
         REQUEST: begin
            // leaving green is the acknowledge and beats a withdrawal
            if (!bus.grn) begin
               state_nxt = SERVED;
            end else if (!pres && !LATCH) begin
               state_nxt = IDLE;
            end
         end
         SERVED: begin
            if (bus.grn) begin
               if (pres) begin
                  state_nxt = QUALIFY;
                  qcnt_nxt  = Q_LOAD;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign bus.car      = (state == REQUEST);
   assign bus.presence = pres;
   assign bus.veh_cnt  = cnt;

endmodule
